// File: rtl/tile_fetch.sv
// Clocked tile-ROM pixel fetch: (tile, x, y, rotate, mirror) -> ROM address, one-outstanding
// ROM handshake with timeout/error colour. Optional one-entry cache under TILE_FETCH_CACHE_EN.
module tile_fetch #(
  parameter int                TILE_LOG2      = 2,
  parameter int                NUM_TILES_LOG2 = 4,
  parameter int                RGB_W          = 24,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [RGB_W-1:0]  ERR_COLOR      = 24'hFF00FF
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic [NUM_TILES_LOG2-1:0]                     i_tile_no,
  input  logic [TILE_LOG2-1:0]                          i_tile_x,
  input  logic [TILE_LOG2-1:0]                          i_tile_y,
  input  logic [1:0]                                    i_rotate,
  input  logic [1:0]                                    i_mirror,
  input  logic                                          i_read,
  output logic                                          o_busy,
  output logic [RGB_W-1:0]                              o_rgb_data,
  output logic                                          o_valid,
  output logic                                          o_error,
  input  logic [RGB_W-1:0]                              i_rom_data,
  input  logic                                          i_rom_valid,
  output logic [NUM_TILES_LOG2+2*TILE_LOG2-1:0]         o_rom_address,
  output logic                                          o_rom_read
);

  localparam int ADDR_W = NUM_TILES_LOG2 + 2*TILE_LOG2;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // T-1-c equals ~c for a TILE_LOG2-bit coordinate, so rotation/mirror is pure inversion and swap.
  function automatic logic [ADDR_W-1:0] map_addr(
    input logic [NUM_TILES_LOG2-1:0] tile,
    input logic [TILE_LOG2-1:0]      x,
    input logic [TILE_LOG2-1:0]      y,
    input logic [1:0]                rot,
    input logic [1:0]                mir
  );
    logic [TILE_LOG2-1:0] xr, yr;
    case (rot)
      2'd0:    begin xr = x;  yr = y;  end
      2'd1:    begin xr = y;  yr = ~x; end
      2'd2:    begin xr = ~x; yr = ~y; end
      default: begin xr = ~y; yr = x;  end
    endcase
    if (mir[0]) yr = ~yr;
    if (mir[1]) xr = ~xr;
    return {tile, yr, xr};
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic [ADDR_W-1:0]  req_addr;
  logic               cache_hit;
  logic [RGB_W-1:0]   cache_rd;

  assign req_addr = map_addr(i_tile_no, i_tile_x, i_tile_y, i_rotate, i_mirror);

`ifdef TILE_FETCH_CACHE_EN
  logic               cache_vld_q, cache_vld_d;
  logic [ADDR_W-1:0]  cache_addr_q, cache_addr_d;
  logic [RGB_W-1:0]   cache_data_q, cache_data_d;

  assign cache_hit = cache_vld_q && (cache_addr_q == req_addr);
  assign cache_rd  = cache_data_q;

  always_comb begin
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
    cache_data_d = cache_data_q;
    if (state_q == S_WAIT && i_rom_valid) begin
      cache_vld_d  = 1'b1;
      cache_addr_d = addr_q;
      cache_data_d = i_rom_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cache_vld_q <= 1'b0;
    else       cache_vld_q <= cache_vld_d;
    cache_addr_q <= cache_addr_d;
    cache_data_q <= cache_data_d;
  end
`else
  assign cache_hit = 1'b0;
  assign cache_rd  = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rgb_d   = rgb_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_read) begin
          if (cache_hit) begin
            rgb_d   = cache_rd;
            valid_d = 1'b1;
          end else begin
            addr_d  = req_addr;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A valid in the final WAIT cycle still beats the timeout.
        if (i_rom_valid) begin
          rgb_d   = i_rom_data;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
          rgb_d   = ERR_COLOR;
          valid_d = 1'b1;
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rgb_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rgb_q   <= rgb_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_rom_read    = (state_q == S_ISSUE);
  assign o_rom_address = addr_q;
  assign o_rgb_data    = rgb_q;
  assign o_valid       = valid_q;
  assign o_error       = error_q;

endmodule
